// File: rtl/crg_switch_seq.sv
// Clock-switch sequencer for the CRG select/enable/reset-request inputs.
// Each accepted request runs gate -> dead time -> select change -> settle
// -> optional reset pulse -> ungate. One request is handled at a time.
// Optional build macro: CRG_SEQ_AUTO_RST_EN (every request pulses a reset).
module crg_switch_seq #(
  parameter int unsigned M          = 4,
  parameter int unsigned N          = 8,
  parameter int unsigned DEAD_CYC   = 8,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned RST_CYC    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [$clog2(N)-1:0] req_ch_i,
  input  logic [$clog2(M)-1:0] req_sel_i,
  input  logic                 req_rst_i,
  input  logic                 ch_en_i    [N],
  output logic [$clog2(M)-1:0] sel_o      [N],
  output logic                 en_o       [N],
  output logic                 arst_req_o [N],
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned SW = $clog2(M);
  localparam int unsigned MaxDs  = (DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC;
  localparam int unsigned MaxCyc = (MaxDs > RST_CYC) ? MaxDs : RST_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  typedef enum logic [2:0] {
    StIdle,
    StGate,
    StSettle,
    StReset,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   ch_q;
  logic [SW-1:0]   sel_new_q;
  logic            rst_q;
  logic            err_q;

  logic [SW-1:0]   sel_q  [N];
  logic            gate_q [N];
  logic            arst_q [N];

  logic            eff_rst;
  logic            accept;
  logic            bad_req;
  logic            same_sel;
  logic [SW-1:0]   cur_sel;
  logic [CW-1:0]   tgt_ch;
  logic            gate_set, gate_clr, sel_upd, arst_set, arst_clr;

`ifdef CRG_SEQ_AUTO_RST_EN
  logic unused_req_rst;
  assign unused_req_rst = req_rst_i;
  assign eff_rst        = 1'b1;
`else
  assign eff_rst        = req_rst_i;
`endif

  assign req_ready_o = (state_q == StIdle) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign bad_req     = (32'(req_ch_i) >= N) || (32'(req_sel_i) >= M);
  assign same_sel    = (cur_sel == req_sel_i);
  // While idle the request fields address the channel; afterwards the latch does.
  assign tgt_ch      = (state_q == StIdle) ? req_ch_i : ch_q;

  // Current select of the requested channel; out-of-range channels read as zero.
  always_comb begin
    cur_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ch_i == CW'(i)) cur_sel = sel_q[i];
    end
  end

  // Next-state logic and per-state channel strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gate_set = 1'b0;
    gate_clr = 1'b0;
    sel_upd  = 1'b0;
    arst_set = 1'b0;
    arst_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bad_req || (same_sel && !eff_rst)) begin
            state_d = StDone;
          end else begin
            state_d  = StGate;
            cnt_d    = CntW'(DEAD_CYC - 1);
            gate_set = 1'b1;
          end
        end
      end
      StGate: begin
        if (cnt_q == '0) begin
          state_d = StSettle;
          cnt_d   = CntW'(SETTLE_CYC - 1);
          sel_upd = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          if (rst_q) begin
            state_d  = StReset;
            cnt_d    = CntW'(RST_CYC - 1);
            arst_set = 1'b1;
          end else begin
            state_d  = StDone;
            gate_clr = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StReset: begin
        if (cnt_q == '0) begin
          state_d  = StDone;
          gate_clr = 1'b1;
          arst_clr = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state and the request latched at the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ch_q      <= '0;
      sel_new_q <= '0;
      rst_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ch_q      <= req_ch_i;
        sel_new_q <= req_sel_i;
        rst_q     <= eff_rst;
        err_q     <= bad_req;
      end
    end
  end

  // Per-channel gate, select and reset-request registers; only the target moves.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N; i++) begin
      if (rst_i) begin
        gate_q[i] <= 1'b0;
        sel_q[i]  <= '0;
        arst_q[i] <= 1'b0;
      end else if (tgt_ch == CW'(i)) begin
        if (gate_set) begin
          gate_q[i] <= 1'b1;
        end else if (gate_clr) begin
          gate_q[i] <= 1'b0;
        end
        if (sel_upd) sel_q[i] <= sel_new_q;
        if (arst_set) begin
          arst_q[i] <= 1'b1;
        end else if (arst_clr) begin
          arst_q[i] <= 1'b0;
        end
      end
    end
  end

  // Channel outputs: software enable passes through unless gated.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      en_o[i]       = ch_en_i[i] & ~gate_q[i];
      sel_o[i]      = sel_q[i];
      arst_req_o[i] = arst_q[i];
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = (state_q == StDone);
    err_o  = (state_q == StDone) && err_q;
  end

endmodule

// File: tb/tb_crg_switch_seq.sv
// Bench for crg_switch_seq (N=6, M=3 to reach both reject paths).
// Reference model: per-request timeline computed from the cycle offset since
// acceptance; honours CRG_SEQ_AUTO_RST_EN when defined.
module tb_crg_switch_seq;

  localparam int M  = 3;
  localparam int N  = 6;
  localparam int D  = 8;
  localparam int S  = 16;
  localparam int R  = 4;
  localparam int CW = $clog2(N);
  localparam int SW = $clog2(M);

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_ch;
  logic [SW-1:0] req_sel;
  logic          req_rst;
  logic          ch_en  [N];
  logic [SW-1:0] sel_o  [N];
  logic          en_o   [N];
  logic          arst_o [N];
  logic          busy, done, err;

  crg_switch_seq #(
    .M          (M),
    .N          (N),
    .DEAD_CYC   (D),
    .SETTLE_CYC (S),
    .RST_CYC    (R)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_ch_i    (req_ch),
    .req_sel_i   (req_sel),
    .req_rst_i   (req_rst),
    .ch_en_i     (ch_en),
    .sel_o       (sel_o),
    .en_o        (en_o),
    .arst_req_o  (arst_o),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: k = cycles since acceptance (0 = idle), L = cycle of completion.
  int k, L, m_ch, m_new;
  bit m_err, m_fast, m_rst;
  int m_sel [N];
  bit seen_done, seen_err;

  typedef struct {
    int ch;
    int sel;
    bit rst;
    bit err;
    int lat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s idx=%0d cyc=%0d got=%0d want=%0d", name, idx, cyc, act, exp);
    end
  endtask

  // Check one cycle against the model, then advance model and clock.
  task automatic step();
    bit eff;
    bit eg, ea;
    int es;
    @(negedge clk);
    seen_done = done;
    seen_err  = err;
    chk("ready", -1, int'(req_ready), int'(k == 0 && !rst_i));
    chk("busy",  -1, int'(busy), int'(k != 0));
    chk("done",  -1, int'(done), int'(k != 0 && k == L));
    chk("err",   -1, int'(err),  int'(k != 0 && k == L && m_err));
    for (int i = 0; i < N; i++) begin
      eg = 1'b0;
      ea = 1'b0;
      es = m_sel[i];
      if (k != 0 && !m_err && !m_fast && i == m_ch) begin
        eg = (k < L);
        if (k >= D + 1) es = m_new;
        ea = m_rst && (k > D + S) && (k <= D + S + R);
      end
      chk("en",   i, int'(en_o[i]), int'(ch_en[i] & ~eg));
      chk("sel",  i, int'(sel_o[i]), es);
      chk("arst", i, int'(arst_o[i]), int'(ea));
    end
    if (rst_i) begin
      k = 0;
      for (int i = 0; i < N; i++) m_sel[i] = 0;
    end else if (k == 0) begin
      if (req_valid) begin
`ifdef CRG_SEQ_AUTO_RST_EN
        eff = 1'b1;
`else
        eff = req_rst;
`endif
        m_ch   = int'(req_ch);
        m_new  = int'(req_sel);
        m_rst  = eff;
        m_err  = (m_ch >= N) || (m_new >= M);
        m_fast = !m_err && (m_sel[m_ch] == m_new) && !eff;
        L      = (m_err || m_fast) ? 1 : (D + S + 1 + (eff ? R : 0));
        k      = 1;
      end
    end else if (k == L) begin
      if (!m_err && !m_fast) m_sel[m_ch] = m_new;
      k = 0;
    end else begin
      k++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Apply one table request, holding valid high (with scrambled fields) while busy.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit got;
    bit got_err;
    req_valid = 1'b1;
    req_ch    = CW'(v.ch);
    req_sel   = SW'(v.sel);
    req_rst   = v.rst;
    step();
    lat     = 0;
    got     = 1'b0;
    got_err = 1'b0;
    if (seen_done) begin
      // Completion cannot coincide with acceptance; report it as latency 0.
      got = 1'b1;
    end
    for (int c = 1; c <= 60 && !got; c++) begin
      req_ch  = CW'($urandom_range(0, 7));
      req_sel = SW'($urandom_range(0, 3));
      req_rst = 1'($urandom_range(0, 1));
      step();
      if (seen_done) begin
        got     = 1'b1;
        lat     = c;
        got_err = seen_err;
      end
    end
    req_valid = 1'b0;
    chk("vec_lat", idx, lat, v.lat);
    chk("vec_err", idx, int'(got_err), int'(v.err));
    step();
  endtask

  initial begin
    int dcnt;
    int full;
`ifdef CRG_SEQ_AUTO_RST_EN
    full = D + S + R + 1;
    vecs[0] = '{ch: 3, sel: 2, rst: 1'b0, err: 1'b0, lat: full};
    vecs[2] = '{ch: 3, sel: 2, rst: 1'b0, err: 1'b0, lat: full};
    vecs[7] = '{ch: 5, sel: 1, rst: 1'b0, err: 1'b0, lat: full};
    vecs[8] = '{ch: 2, sel: 2, rst: 1'b0, err: 1'b0, lat: full};
`else
    full = D + S + R + 1;
    vecs[0] = '{ch: 3, sel: 2, rst: 1'b0, err: 1'b0, lat: D + S + 1};
    vecs[2] = '{ch: 3, sel: 2, rst: 1'b0, err: 1'b0, lat: 1};
    vecs[7] = '{ch: 5, sel: 1, rst: 1'b0, err: 1'b0, lat: 1};
    vecs[8] = '{ch: 2, sel: 2, rst: 1'b0, err: 1'b0, lat: D + S + 1};
`endif
    vecs[1] = '{ch: 5, sel: 1, rst: 1'b1, err: 1'b0, lat: full};
    vecs[3] = '{ch: 7, sel: 1, rst: 1'b0, err: 1'b1, lat: 1};
    vecs[4] = '{ch: 6, sel: 0, rst: 1'b1, err: 1'b1, lat: 1};
    vecs[5] = '{ch: 1, sel: 3, rst: 1'b0, err: 1'b1, lat: 1};
    vecs[6] = '{ch: 0, sel: 0, rst: 1'b1, err: 1'b0, lat: full};

    rst_i     = 1'b1;
    req_valid = 1'b0;
    req_ch    = '0;
    req_sel   = '0;
    req_rst   = 1'b0;
    for (int i = 0; i < N; i++) ch_en[i] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    k = 0;
    L = 0;
    m_ch = 0;
    m_new = 0;
    m_err = 1'b0;
    m_fast = 1'b0;
    m_rst = 1'b0;
    for (int i = 0; i < N; i++) m_sel[i] = 0;
    rst_i = 1'b0;

    // Post-reset idle state.
    step();
    step();

    for (int v = 0; v < 9; v++) run_vec(vecs[v], v);

    // Reset in the middle of a ch=2 request at T+12 aborts it without done.
    req_valid = 1'b1;
    req_ch    = CW'(2);
    req_sel   = SW'(1);
    req_rst   = 1'b0;
    step();
    req_valid = 1'b0;
    repeat (11) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("abort_sel2", 2, int'(sel_o[2]), 0);
    chk("abort_en2",  2, int'(en_o[2]), 1);
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      dcnt += int'(seen_done);
    end
    chk("abort_no_done", -1, dcnt, 0);

    // Randomized traffic including enables and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_ch    = CW'($urandom_range(0, 7));
      req_sel   = SW'($urandom_range(0, 3));
      req_rst   = 1'($urandom_range(0, 1));
      rst_i     = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) ch_en[i] = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
